// File: rtl/mux4to1_pkg.sv
// Shared select encodings and types for the 4:1 lane selector.
package mux4to1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'b00;
  localparam sel_t SEL_I1 = 2'b01;
  localparam sel_t SEL_I2 = 2'b10;
  localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux4to1_sel_if.sv
// Signal bundle for the 4:1 selector: select/lanes/enable in, combinational and registered lane out.
interface mux4to1_sel_if #(
  parameter int WIDTH = 1
);
  import mux4to1_pkg::*;

  // No valid/ready pair: y is valid whenever s and i are stable; y_q loads y
  // on every rising clk where en is high and otherwise holds.
  sel_t               s;
  logic [4*WIDTH-1:0] i;
  logic               en;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   y_q;

  modport master (output s, i, en, input  y, y_q);
  modport slave  (input  s, i, en, output y, y_q);
  modport core   (input  s, i,     output y);

endinterface

// File: rtl/mux4to1_core.sv
// Pure combinational 4:1 lane selector; unknown select resolves to lane 0, or to
// UDP-style X merging when MUX4TO1_SEL_XPROP_EN is defined (simulation only).
module mux4to1_core
  import mux4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  mux4to1_sel_if.core bus
);

  logic [WIDTH-1:0] lane [4];
  logic [WIDTH-1:0] y_d;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane[k] = bus.i[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    y_d = lane[0];
    case (bus.s)
      SEL_I0:  y_d = lane[0];
      SEL_I1:  y_d = lane[1];
      SEL_I2:  y_d = lane[2];
      SEL_I3:  y_d = lane[3];
      default: begin
`ifdef MUX4TO1_SEL_XPROP_EN
        // Only reachable with X/Z on s: bits where all lanes agree survive.
        y_d = lane[0];
        for (int b = 0; b < WIDTH; b++) begin
          if ((lane[1][b] !== lane[0][b]) || (lane[2][b] !== lane[0][b]) ||
              (lane[3][b] !== lane[0][b])) begin
            y_d[b] = 1'bx;
          end
        end
`else
        y_d = lane[0];
`endif
      end
    endcase
  end

  assign bus.y = y_d;

endmodule

// File: rtl/mux4to1_sel.sv
// 4:1 lane selector with combinational output y and enable-gated registered copy y_q.
// Optional simulation X-propagation on unknown select: define MUX4TO1_SEL_XPROP_EN.
module mux4to1_sel
  import mux4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0]   y,
  input  sel_t               s,
  input  logic [4*WIDTH-1:0] i,
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [WIDTH-1:0]   y_q
);

  mux4to1_sel_if #(.WIDTH(WIDTH)) bus ();

  assign bus.s  = s;
  assign bus.i  = i;
  assign bus.en = en;

  mux4to1_core #(.WIDTH(WIDTH)) u_core (
    .bus (bus)
  );

  assign y = bus.y;

  logic [WIDTH-1:0] y_q_q;
  logic [WIDTH-1:0] y_q_d;

  always_comb begin
    y_q_d = bus.en ? bus.y : y_q_q;
  end

  // Reset touches only the register; y stays a function of s and i throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_q <= '0;
    end else begin
      y_q_q <= y_q_d;
    end
  end

  assign bus.y_q = y_q_q;
  assign y_q     = bus.y_q;

endmodule

// File: tb/tb_mux4to1_sel.sv
// Bench for mux4to1_sel: WIDTH=1 and WIDTH=8 instances, reference model plus scoreboard queue.
module tb_mux4to1_sel;

  logic clk;
  logic rst_n;

  mux4to1_sel_if #(.WIDTH(1)) if1 ();
  mux4to1_sel_if #(.WIDTH(8)) if8 ();

  mux4to1_sel #(.WIDTH(1)) dut1 (
    .y     (if1.y),
    .s     (if1.s),
    .i     (if1.i),
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if1.en),
    .y_q   (if1.y_q)
  );

  mux4to1_sel #(.WIDTH(8)) dut8 (
    .y     (if8.y),
    .s     (if8.s),
    .i     (if8.i),
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if8.en),
    .y_q   (if8.y_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] y1;
    logic [7:0] yq1;
    logic [7:0] y8;
    logic [7:0] yq8;
  } exp_t;

  exp_t exp_q[$];
  event smp_ev;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] mdl_yq1 = 8'h00;
  logic [7:0] mdl_yq8 = 8'h00;

  // Reference: lane k is i[k*w +: w]; unknown select -> lane 0 (or merged lanes).
  function automatic logic [7:0] ref_y(input logic [1:0] s, input logic [31:0] i, input int w);
    logic [7:0] l [4];
    logic [7:0] m;
    logic [7:0] r;
    m = 8'((32'd1 << w) - 32'd1);
    for (int k = 0; k < 4; k++) l[k] = 8'(i >> (k * w)) & m;
    if (^s === 1'bx) begin
      r = l[0];
`ifdef MUX4TO1_SEL_XPROP_EN
      for (int b = 0; b < w; b++)
        if ((l[1][b] !== l[0][b]) || (l[2][b] !== l[0][b]) || (l[3][b] !== l[0][b]))
          r[b] = 1'bx;
`endif
      return r;
    end
    return l[s];
  endfunction

  function automatic logic [7:0] exp_y1();
    return ref_y(if1.s, {28'd0, if1.i}, 1);
  endfunction

  function automatic logic [7:0] exp_y8();
    return ref_y(if8.s, if8.i, 8);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (if1.en) mdl_yq1 = exp_y1();
      if (if8.en) mdl_yq8 = exp_y8();
    end
    #1;
  endtask

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) begin
      mdl_yq1 = 8'h00;
      mdl_yq8 = 8'h00;
    end
  endtask

  task automatic sample(input string name);
    exp_t e;
    e.name = name;
    e.y1   = exp_y1();
    e.yq1  = mdl_yq1;
    e.y8   = exp_y8();
    e.yq8  = mdl_yq8;
    exp_q.push_back(e);
    #2;
    -> smp_ev;
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(smp_ev);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL queue_empty: got no expectation, required one at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_y1"},  {7'd0, if1.y},   e.y1);
        chk({e.name, "_yq1"}, {7'd0, if1.y_q}, e.yq1);
        chk({e.name, "_y8"},  if8.y,           e.y8);
        chk({e.name, "_yq8"}, if8.y_q,         e.yq8);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  logic [1:0] s_tab [4];
  logic [3:0] i_tab [4];

  initial begin
    s_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
    i_tab = '{4'b0101, 4'b1001, 4'b1110, 4'b1101};

    set_rst(1'b0);
    if1.s = 2'b00; if1.i = 4'b0000; if1.en = 1'b0;
    if8.s = 2'b00; if8.i = 32'h0;   if8.en = 1'b0;
    #3;
    sample("reset");
    tick();
    set_rst(1'b1);

    // combinational stepping, lane table 1101
    if1.i = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      if1.s = 2'(k);
      sample("step");
    end

    tick();
    for (int k = 0; k < 4; k++) begin
      if1.s = s_tab[k];
      if1.i = i_tab[k];
      sample("pair");
    end

    // async reset mid-cycle, then release and recapture
    if1.en = 1'b1; if1.s = 2'b11; if1.i = 4'b1000;
    tick();
    sample("yq_set");
    set_rst(1'b0);
    sample("async_rst");
    tick();
    sample("in_rst");
    set_rst(1'b1);
    tick();
    sample("rst_release");

    // enable gating
    if1.en = 1'b0; if1.s = 2'b01; if1.i = 4'b0000;
    sample("en_hold0");
    for (int k = 0; k < 3; k++) begin
      tick();
      sample("en_hold");
    end
    if1.en = 1'b1;
    tick();
    sample("en_cap");

    // 8-bit lanes A1..D4
    if8.en = 1'b1;
    if8.i  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int k = 0; k < 4; k++) begin
      if8.s = 2'(k);
      sample("w8_y");
      tick();
      sample("w8_yq");
    end

    // unknown select
    if1.en = 1'b0; if8.en = 1'b0;
    if1.s = 2'bxx; if1.i = 4'b1101;
    sample("xsel_1101");
    if1.i = 4'b1111;
    sample("xsel_1111");
    if1.s = 2'b00;
    tick();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      if1.s  = 2'($urandom_range(0, 3));
      if1.i  = 4'($urandom_range(0, 15));
      if1.en = 1'($urandom_range(0, 1));
      if8.s  = 2'($urandom_range(0, 3));
      if8.i  = $urandom();
      if8.en = 1'($urandom_range(0, 1));
      sample("rand");
      if ($urandom_range(0, 15) == 0) begin
        set_rst(1'b0);
        sample("rand_rst");
        set_rst(1'b1);
      end
      tick();
      sample("rand_edge");
    end

    #5;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
